bump_recov_seq: RTL and testbench

//  Sequences the drive datapath after a front-bumper hit. Sits between PID speed outputs and mtr_drv.
//  In normal line following it passes the PID speeds through registered.
//  On a bump it takes over the motors: brake, back up, pivot away from the hit side, settle, then

---
 rtl/bump_recov_seq.sv | 205 ++++++++++++++++++++
 tb/tb_bump_recov_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bump_recov_seq.sv
// -----------------------------------------------------------------------------
// bump_recov_seq
//   Drive-path sequencer placed between the PID speed outputs and mtr_drv.
//   In line following it passes the PID speeds through one register stage.
//   After a front-bumper hit it takes over the motors:
//      BRAKE (zero) -> BACKUP (reverse) -> TURN (pivot away from hit) -> SETTLE (zero)
//   and then hands control back to the PID. While recovering it holds go_out low
//   so the PID integrator restarts from a clean state.
//
// Ports
//   clk           in   1   system clock (50 MHz)
//   rst           in   1   asynchronous active-high reset
//   BMPL_n        in   1   left bump switch, active low, asynchronous to clk
//   BMPR_n        in   1   right bump switch, active low, asynchronous to clk
//   go_in         in   1   run enable from cmd_proc
//   pid_lft_spd   in  12   signed left speed from PID
//   pid_rght_spd  in  12   signed right speed from PID
//   lft_spd       out 12   signed left duty to mtr_drv (registered)
//   rght_spd      out 12   signed right duty to mtr_drv (registered)
//   go_out        out  1   go to PID, forced low while recovering (registered)
//   recov         out  1   high whenever the sequencer is not following (registered)
//   turn_rght     out  1   pivot direction of the current or last recovery
//   recov_cnt     out  8   saturating count of completed recoveries
// -----------------------------------------------------------------------------
module bump_recov_seq #(
   parameter logic [23:0] STOP_CYC = 24'd2_500_000,
   parameter logic [23:0] BACK_CYC = 24'd12_500_000,
   parameter logic [23:0] TURN_CYC = 24'd10_000_000,
   parameter logic [11:0] BACK_SPD = 12'd600,
   parameter logic [11:0] TURN_SPD = 12'd500
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        BMPL_n,
   input  logic        BMPR_n,
   input  logic        go_in,
   input  logic [11:0] pid_lft_spd,
   input  logic [11:0] pid_rght_spd,
   output logic [11:0] lft_spd,
   output logic [11:0] rght_spd,
   output logic        go_out,
   output logic        recov,
   output logic        turn_rght,
   output logic [7:0]  recov_cnt
);

   typedef enum logic [2:0] {
      FOLLOW = 3'd0,
      BRAKE  = 3'd1,
      BACKUP = 3'd2,
      TURN   = 3'd3,
      SETTLE = 3'd4
   } state_t;

   localparam logic [11:0] NEG_BACK = 12'd0 - BACK_SPD;
   localparam logic [11:0] POS_TURN = TURN_SPD;
   localparam logic [11:0] NEG_TURN = 12'd0 - TURN_SPD;

   state_t      state_reg, state_next;
   logic [23:0] timer_reg, timer_next;
   logic        turn_rght_reg, turn_rght_next;
   logic [7:0]  recov_cnt_reg, recov_cnt_next;
   logic [11:0] lft_reg, lft_next;
   logic [11:0] rght_reg, rght_next;
   logic        go_out_reg, go_out_next;
   logic        recov_reg, recov_next;

   // Bump shift registers: [0] first sync flop, [1] synchronized value,
   // [2] previous synchronized value. Preset to 1 so that reset looks like
   // "not pressed" and a switch already held at reset release produces an edge.
   logic [2:0]  bmpl_sh_reg;
   logic [2:0]  bmpr_sh_reg;
   logic        bmp_fall_l;
   logic        bmp_fall_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bmpl_sh_reg <= 3'b111;
         bmpr_sh_reg <= 3'b111;
      end else begin
         bmpl_sh_reg <= {bmpl_sh_reg[1:0], BMPL_n};
         bmpr_sh_reg <= {bmpr_sh_reg[1:0], BMPR_n};
      end
   end

   assign bmp_fall_l = bmpl_sh_reg[2] & ~bmpl_sh_reg[1];
   assign bmp_fall_r = bmpr_sh_reg[2] & ~bmpr_sh_reg[1];

   // State, timer and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= FOLLOW;
         timer_reg     <= '0;
         turn_rght_reg <= 1'b0;
         recov_cnt_reg <= '0;
         lft_reg       <= '0;
         rght_reg      <= '0;
         go_out_reg    <= 1'b0;
         recov_reg     <= 1'b0;
      end else begin
         state_reg     <= state_next;
         timer_reg     <= timer_next;
         turn_rght_reg <= turn_rght_next;
         recov_cnt_reg <= recov_cnt_next;
         lft_reg       <= lft_next;
         rght_reg      <= rght_next;
         go_out_reg    <= go_out_next;
         recov_reg     <= recov_next;
      end
   end

   // Next-state and next-output logic. Outputs are derived from the current
   // state, so they appear one clock after the state that produces them.
   // The timer is loaded with CYC-1 on entry and the state advances on the
   // clock where it reads zero, giving exactly CYC clocks per state.
   always_comb begin
      state_next     = state_reg;
      timer_next     = timer_reg;
      turn_rght_next = turn_rght_reg;
      recov_cnt_next = recov_cnt_reg;
      lft_next       = '0;
      rght_next      = '0;
      go_out_next    = 1'b0;
      recov_next     = (state_reg != FOLLOW);

      case (state_reg)
         FOLLOW: begin
            lft_next    = pid_lft_spd;
            rght_next   = pid_rght_spd;
            go_out_next = go_in;
            if (go_in && (bmp_fall_l || bmp_fall_r)) begin
               state_next     = BRAKE;
               timer_next     = STOP_CYC - 24'd1;
               // A left hit (alone or together with the right) pivots right.
               turn_rght_next = bmp_fall_l;
            end
         end

         BRAKE: begin
            if (timer_reg == 24'd0) begin
               state_next = BACKUP;
               timer_next = BACK_CYC - 24'd1;
            end else begin
               timer_next = timer_reg - 24'd1;
            end
         end

         BACKUP: begin
            lft_next  = NEG_BACK;
            rght_next = NEG_BACK;
            if (timer_reg == 24'd0) begin
               state_next = TURN;
               timer_next = TURN_CYC - 24'd1;
            end else begin
               timer_next = timer_reg - 24'd1;
            end
         end

         TURN: begin
            lft_next  = turn_rght_reg ? POS_TURN : NEG_TURN;
            rght_next = turn_rght_reg ? NEG_TURN : POS_TURN;
            if (timer_reg == 24'd0) begin
               state_next = SETTLE;
               timer_next = STOP_CYC - 24'd1;
            end else begin
               timer_next = timer_reg - 24'd1;
            end
         end

         SETTLE: begin
            if (timer_reg == 24'd0) begin
               state_next = FOLLOW;
               if (recov_cnt_reg != 8'hFF) begin
                  recov_cnt_next = recov_cnt_reg + 8'd1;
               end
            end else begin
               timer_next = timer_reg - 24'd1;
            end
         end

         default: begin
            state_next = FOLLOW;
            timer_next = '0;
         end
      endcase

      // Losing go mid-recovery aborts straight back to FOLLOW with the motors
      // stopped; the aborted recovery is not counted.
      if ((state_reg != FOLLOW) && !go_in) begin
         state_next     = FOLLOW;
         timer_next     = '0;
         lft_next       = '0;
         rght_next      = '0;
         recov_cnt_next = recov_cnt_reg;
      end
   end

   assign lft_spd   = lft_reg;
   assign rght_spd  = rght_reg;
   assign go_out    = go_out_reg;
   assign recov     = recov_reg;
   assign turn_rght = turn_rght_reg;
   assign recov_cnt = recov_cnt_reg;

endmodule

// File: tb/tb_bump_recov_seq.sv
// -----------------------------------------------------------------------------
// tb_bump_recov_seq
//   Self-checking bench for bump_recov_seq with short phase lengths (4/8/6).
//   A queue-based model predicts every output on every clock; directed
//   scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_bump_recov_seq;

   localparam int STOP = 4;
   localparam int BACK = 8;
   localparam int TRN  = 6;
   localparam int RECOV_LEN = 2 * STOP + BACK + TRN;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        BMPL_n = 1'b1;
   logic        BMPR_n = 1'b1;
   logic        go_in = 1'b0;
   logic [11:0] pid_lft_spd = '0;
   logic [11:0] pid_rght_spd = '0;
   logic [11:0] lft_spd;
   logic [11:0] rght_spd;
   logic        go_out;
   logic        recov;
   logic        turn_rght;
   logic [7:0]  recov_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bump_recov_seq #(
      .STOP_CYC(24'd4),
      .BACK_CYC(24'd8),
      .TURN_CYC(24'd6),
      .BACK_SPD(12'd600),
      .TURN_SPD(12'd500)
   ) dut (
      .clk(clk),
      .rst(rst),
      .BMPL_n(BMPL_n),
      .BMPR_n(BMPR_n),
      .go_in(go_in),
      .pid_lft_spd(pid_lft_spd),
      .pid_rght_spd(pid_rght_spd),
      .lft_spd(lft_spd),
      .rght_spd(rght_spd),
      .go_out(go_out),
      .recov(recov),
      .turn_rght(turn_rght),
      .recov_cnt(recov_cnt)
   );

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Raw bump samples taken each clock; a press is seen as a new falling edge
   // two samples after it first appears. A recovery is a precomputed list of
   // per-clock speed pairs that is replayed while go stays high.
   logic [2:0] ml = 3'b111;
   logic [2:0] mr = 3'b111;
   int  plan_l[$];
   int  plan_r[$];
   int  exp_l = 0, exp_r = 0, exp_cnt = 0;
   bit  exp_go = 0, exp_recov = 0, exp_turn = 0;

   always @(posedge clk) begin
      bit fl, fr, gi;
      int pl, pr;
      gi = go_in;
      pl = $signed(pid_lft_spd);
      pr = $signed(pid_rght_spd);
      if (rst) begin
         ml = 3'b111; mr = 3'b111;
         plan_l.delete(); plan_r.delete();
         exp_l = 0; exp_r = 0; exp_cnt = 0;
         exp_go = 0; exp_recov = 0; exp_turn = 0;
      end else begin
         fl = ml[2] & ~ml[1];
         fr = mr[2] & ~mr[1];
         ml = {ml[1:0], BMPL_n};
         mr = {mr[1:0], BMPR_n};
         if (plan_l.size() > 0) begin
            exp_recov = 1;
            exp_go = 0;
            if (!gi) begin
               exp_l = 0; exp_r = 0;
               plan_l.delete(); plan_r.delete();
            end else begin
               exp_l = plan_l.pop_front();
               exp_r = plan_r.pop_front();
               if (plan_l.size() == 0 && exp_cnt < 255) exp_cnt++;
            end
         end else begin
            exp_recov = 0;
            exp_l = pl; exp_r = pr;
            exp_go = gi;
            if (gi && (fl || fr)) begin
               exp_turn = fl;
               for (int k = 0; k < STOP; k++) begin plan_l.push_back(0); plan_r.push_back(0); end
               for (int k = 0; k < BACK; k++) begin plan_l.push_back(-600); plan_r.push_back(-600); end
               for (int k = 0; k < TRN; k++) begin
                  plan_l.push_back(fl ? 500 : -500);
                  plan_r.push_back(fl ? -500 : 500);
               end
               for (int k = 0; k < STOP; k++) begin plan_l.push_back(0); plan_r.push_back(0); end
            end
         end
      end
      #1;
      if (!rst) begin
         chk("mdl_lft", $signed(lft_spd), exp_l);
         chk("mdl_rght", $signed(rght_spd), exp_r);
         chk("mdl_go", go_out, exp_go);
         chk("mdl_recov", recov, exp_recov);
         chk("mdl_turn", turn_rght, exp_turn);
         chk("mdl_cnt", recov_cnt, exp_cnt);
      end
   end

   // ---------------- directed scenarios ----------------
   // Wait (bounded) for recov to rise; returns negedges waited.
   task automatic wait_recov(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!recov && n < 20);
   endtask

   // Full recovery with literal per-phase expectations. A second press on
   // both bumpers during BACKUP must be ignored, and bumpers still held after
   // SETTLE must not retrigger.
   task automatic recovery(input bit hit_l, input bit hit_r, input string tag, input bit quiet);
      int n, cnt0, el, er, bad, retrig;
      cnt0 = recov_cnt;
      if (hit_l) BMPL_n = 1'b0;
      if (hit_r) BMPR_n = 1'b0;
      wait_recov(n);
      chk({tag, "_latency"}, n, 4);
      bad = 0;
      for (int i = 0; i < RECOV_LEN; i++) begin
         if (i == 6) begin BMPL_n = 1'b0; BMPR_n = 1'b0; end
         if (i < STOP)                 begin el = 0;    er = 0;    end
         else if (i < STOP + BACK)     begin el = -600; er = -600; end
         else if (i < STOP + BACK + TRN) begin
            el = hit_l ? 500 : -500;
            er = hit_l ? -500 : 500;
         end else                      begin el = 0;    er = 0;    end
         if ($signed(lft_spd) != el || $signed(rght_spd) != er || go_out || !recov) bad++;
         @(negedge clk);
      end
      chk({tag, "_phase_errs"}, bad, 0);
      chk({tag, "_recov_end"}, recov, 0);
      chk({tag, "_cnt"}, recov_cnt, (cnt0 == 255) ? 255 : cnt0 + 1);
      chk({tag, "_turn"}, turn_rght, hit_l);
      retrig = 0;
      for (int i = 0; i < 8; i++) begin
         if (recov) retrig++;
         @(negedge clk);
      end
      chk({tag, "_no_retrig"}, retrig, 0);
      BMPL_n = 1'b1;
      BMPR_n = 1'b1;
      repeat (4) @(negedge clk);
      if (!quiet)
         $display("recovery %s: turn_rght=%0d recov_cnt=%0d", tag, turn_rght, recov_cnt);
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      chk("rst_lft", lft_spd, 0);
      chk("rst_rght", rght_spd, 0);
      chk("rst_go", go_out, 0);
      chk("rst_recov", recov, 0);
      chk("rst_turn", turn_rght, 0);
      chk("rst_cnt", recov_cnt, 0);
      $display("reset: outputs idle");

      rst = 1'b0;
      go_in = 1'b1;
      pid_lft_spd = 12'd300;
      pid_rght_spd = 12'd250;
      @(negedge clk);
      chk("pass_lft", $signed(lft_spd), 300);
      chk("pass_rght", $signed(rght_spd), 250);
      chk("pass_go", go_out, 1);
      chk("pass_recov", recov, 0);
      pid_lft_spd = 12'hF38;   // -200
      pid_rght_spd = 12'h7FF;  // +2047
      @(negedge clk);
      chk("pass_neg_lft", $signed(lft_spd), -200);
      chk("pass_max_rght", $signed(rght_spd), 2047);
      $display("pass-through: lft=%0d rght=%0d", $signed(lft_spd), $signed(rght_spd));
      pid_lft_spd = 12'd300;
      pid_rght_spd = 12'd250;

      recovery(1'b1, 1'b0, "left", 1'b0);
      recovery(1'b0, 1'b1, "right", 1'b0);
      recovery(1'b1, 1'b1, "both", 1'b0);

      // go dropped during TURN: abort to FOLLOW, motors stopped, count held.
      n = recov_cnt;
      BMPR_n = 1'b0;
      wait_recov(n);
      repeat (STOP + BACK + 1) @(negedge clk);
      go_in = 1'b0;
      pid_lft_spd = '0;
      pid_rght_spd = '0;
      @(negedge clk);
      chk("abort_lft", lft_spd, 0);
      chk("abort_rght", rght_spd, 0);
      chk("abort_go", go_out, 0);
      chk("abort_cnt", recov_cnt, 3);
      @(negedge clk);
      chk("abort_recov", recov, 0);
      BMPR_n = 1'b1;
      repeat (4) @(negedge clk);
      go_in = 1'b1;
      pid_lft_spd = 12'd300;
      pid_rght_spd = 12'd250;
      repeat (2) @(negedge clk);
      chk("abort_resume_lft", $signed(lft_spd), 300);
      $display("abort in TURN: recov_cnt=%0d", recov_cnt);

      // rst pulse during BACKUP clears everything without waiting for a clock.
      BMPL_n = 1'b0;
      wait_recov(n);
      repeat (STOP + 2) @(negedge clk);
      #2;
      rst = 1'b1;
      BMPL_n = 1'b1;
      #1;
      chk("arst_lft", lft_spd, 0);
      chk("arst_rght", rght_spd, 0);
      chk("arst_recov", recov, 0);
      chk("arst_cnt", recov_cnt, 0);
      chk("arst_turn", turn_rght, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      $display("reset in BACKUP: recov_cnt=%0d", recov_cnt);

      // Saturation of the recovery counter.
      for (int k = 0; k < 257; k++) recovery(k[0], ~k[0], "sat", 1'b1);
      chk("sat_cnt", recov_cnt, 255);
      $display("saturation: recov_cnt=%0d after 257 recoveries", recov_cnt);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      errors++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
